// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with per-slot anti-ghost blanking and PWM dimming.
// Optional macro LEADING_ZERO_BLANK_EN blanks slot 3 when its held digit is zero.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_BTN,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] hrs1,
  input  logic [3:0] hrs2,
  input  logic [7:0] pwm_in,
  output logic [7:0] SevenSegment,
  output logic [7:0] SegmentDrivers,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;
  logic [7:0]       r_pwm_cnt;
  logic [3:0]       r_digit;
  logic [7:0]       r_duty;

  logic [3:0] w_in_digit;
  logic       w_first;
  logic [3:0] w_digit;
  logic       w_pwm_on;
  logic [7:0] w_anode;
  logic       w_lzb;

  // Segment pattern {g,f,e,d,c,b,a}, active-high; non-BCD values light nothing
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  always_comb begin
    w_in_digit = min1;
    case (r_slot)
      2'd0: w_in_digit = min1;
      2'd1: w_in_digit = min2;
      2'd2: w_in_digit = hrs1;
      2'd3: w_in_digit = hrs2;
      default: w_in_digit = min1;
    endcase
  end

  // The sampling cycle decodes the fresh input so segments never lag the held digit
  assign w_first  = (r_state == ST_BLANK) && (r_cnt == '0);
  assign w_digit  = w_first ? w_in_digit : r_digit;
  assign w_pwm_on = (r_pwm_cnt < r_duty);
  assign w_anode  = {4'hF, ~(4'b0001 << r_slot)};

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lzb = (r_slot == 2'd3) && (r_digit == 4'd0);
`else
  assign w_lzb = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ or posedge RESET_BTN) begin
    if (RESET_BTN) begin
      r_state        <= ST_BLANK;
      r_cnt          <= '0;
      r_slot         <= 2'd0;
      r_pwm_cnt      <= 8'd0;
      r_digit        <= 4'hF;
      r_duty         <= 8'd0;
      SevenSegment   <= 8'h7F;
      SegmentDrivers <= 8'hFF;
      frame_done     <= 1'b0;
    end else begin
      r_pwm_cnt    <= r_pwm_cnt + 8'd1;
      SevenSegment <= {1'b0, ~seg_decode(w_digit)};
      frame_done   <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          SegmentDrivers <= 8'hFF;
          if (w_first) begin
            r_digit <= w_in_digit;
            r_duty  <= pwm_in;
          end
          if (r_cnt == BLANK_END) r_state <= ST_DRIVE;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_DRIVE: begin
          SegmentDrivers <= (w_pwm_on && !w_lzb) ? w_anode : 8'hFF;
          if (r_cnt == LAST_CNT) begin
            r_cnt      <= '0;
            r_slot     <= r_slot + 2'd1;
            r_state    <= ST_BLANK;
            frame_done <= (r_slot == 2'd3);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range BLANK_CYCLES+2 to 2^20-1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, anti-ghost blanking cycles at the start of each slot; legal range 1 to 255.
REQ-003 CLK100MHZ  input  1  system clock, all logic on rising edge.
REQ-004 RESET_BTN  input  1  reset; asynchronous, active-high.
REQ-005 min1, min2, hrs1, hrs2  input  4 each  BCD digit values, slot 0..3 respectively.
REQ-006 pwm_in  input  8  brightness duty, 0 = dark.
REQ-007 SevenSegment  output  8  cathodes, active-low; [6:0] = {g,f,e,d,c,b,a}; [7] constant 0.
REQ-008 SegmentDrivers  output  8  anodes, active-low one-hot; [7:4] constant 1.
REQ-009 frame_done  output  1  one-cycle pulse on the final cycle of slot 3.

Function
REQ-010 SHALL scan slots in order 0,1,2,3,0,...; slot n drives anode bit n (slot 0 = 8'b11111110, slot 3 = 8'b11110111).
REQ-011 SHALL use a 2-state FSM per slot: BLANK for exactly BLANK_CYCLES cycles, then DRIVE for SCAN_DIV-BLANK_CYCLES cycles; after DRIVE, advance slot and enter BLANK.
REQ-012 In BLANK SHALL drive SegmentDrivers = 8'hFF.
REQ-013 On the first BLANK cycle SHALL sample the slot's digit input and pwm_in into holding registers; input changes mid-slot SHALL NOT affect the current slot.
REQ-014 SevenSegment[6:0] SHALL be the inverted pattern of the held digit: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111 (pre-inversion).
REQ-015 Held digit values 10..15 SHALL produce SevenSegment[6:0] = 7'b1111111 (all off).
REQ-016 A free-running 8-bit PWM counter SHALL increment every cycle and wrap 255->0; in DRIVE the slot anode SHALL be active only while counter < held pwm_in, else 8'hFF.
REQ-017 Held pwm_in = 0 SHALL keep anodes 8'hFF; 255 SHALL give 255/256 on-time.
REQ-018 All outputs SHALL be registered; anode and segment updates SHALL occur on the same edge (no cycle of new anode with old segments).
REQ-019 frame_done SHALL assert for exactly one cycle every 4*SCAN_DIV cycles.
REQ-020 Slot/phase counter SHALL be sized for SCAN_DIV with no overflow; no other wrap besides REQ-016.

Reset
REQ-021 While RESET_BTN is high: slot = 0, FSM = BLANK, slot counter = 0, PWM counter = 0, held digit = 4'hF, held pwm = 0, SegmentDrivers = 8'hFF, SevenSegment = 8'h7F, frame_done = 0.
REQ-022 Reset asserted mid-slot SHALL force REQ-021 values asynchronously; after release, first BLANK cycle begins on the next rising edge.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN: when defined, slot 3 with held hrs2 = 0 SHALL keep SegmentDrivers = 8'hFF for the whole slot (slot timing and frame_done unchanged); when undefined, 0 SHALL be displayed normally.

Verification (SCAN_DIV=20, BLANK_CYCLES=4)
REQ-024 Reset release, digits 1,2,3,4, pwm_in=255 -> anodes 8'hFF 4 cycles then 8'hFE with SevenSegment 8'h79 (digit 1) except PWM-off cycles; slot 1 begins 20 cycles after slot 0, frame_done every 80 cycles.
REQ-025 pwm_in=0 -> SegmentDrivers 8'hFF for an entire frame; pwm_in=128 -> each anode active on exactly the counter<128 cycles of DRIVE.
REQ-026 min1 changed 3->7 mid-slot 0 -> slot 0 still shows 3; next slot 0 shows 7 (SevenSegment 8'h78).
REQ-027 hrs2=12 -> slot 3 SevenSegment 8'h7F; hrs2=0 -> 8'h40 shown without macro, anodes 8'hFF all slot 3 with LEADING_ZERO_BLANK_EN.
REQ-028 RESET_BTN pulsed mid-slot 2 -> outputs 8'hFF/8'h7F immediately, no clock needed; scan restarts at slot 0.
